// File: rtl/store_beat_sequencer_pkg.sv
// Shared types for the store beat sequencer: access sizes, FSM states and a size helper.
package store_beat_sequencer_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } store_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } store_seq_state_e;

    function automatic logic [3:0] size_bytes(store_size_e sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/store_beat_sequencer_align.sv
// Combinational store path: effective address, lane-shifted data and strobes over a
// two-beat window, plus the fault decision for the accepted store.
module store_lane_align
    import store_beat_sequencer_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic [XLEN-1:0]         base,
    input  logic [XLEN-1:0]         offset,
    input  logic [XLEN-1:0]         data,
    input  store_size_e             size,
    output logic [XLEN-1:0]         ea,
    output logic [2*(XLEN/8)-1:0]   ext_strb,
    output logic [2*XLEN-1:0]       ext_data,
    output logic                    fault
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    logic [OW-1:0]   off;
    logic [3:0]      nbytes;
    logic [15:0]     mask16;
    logic [2*NB-1:0] mask;
    logic            misaligned;

    assign ea     = base + offset;
    assign off    = ea[OW-1:0];
    assign nbytes = size_bytes(size);
    assign mask16 = (16'd1 << nbytes) - 16'd1;
    assign mask   = mask16[2*NB-1:0];

    assign ext_strb = mask << off;
    assign ext_data = {{XLEN{1'b0}}, data} << {off, 3'b000};

    // nbytes never exceeds NB on a legal store, so the low address bits decide alignment.
    assign misaligned = |(4'(off) & (nbytes - 4'd1));

    assign fault = ((size == SZ_D) && (XLEN == 32)) || (!SPLIT_MISALIGNED && misaligned);

endmodule

// File: rtl/store_beat_sequencer.sv
// Store sequencer: accepts one store, issues one or two aligned write beats over a
// valid/ready port, then pulses done (with fault for unsupported or disallowed stores).
module store_beat_sequencer
    import store_beat_sequencer_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [1:0]          i_size,
    input  logic [XLEN-1:0]     i_base,
    input  logic [XLEN-1:0]     i_offset,
    input  logic [XLEN-1:0]     i_data,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic [XLEN-1:0]     o_mem_addr,
    output logic [XLEN-1:0]     o_mem_wdata,
    output logic [XLEN/8-1:0]   o_mem_wstrb,
    output logic                o_done,
    output logic                o_fault,
    output logic [XLEN-1:0]     o_fault_addr
);

    localparam int unsigned     NB         = XLEN / 8;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(NB - 1);

    store_seq_state_e state_q, state_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [NB-1:0]    wstrb_q, wstrb_d;
    logic [XLEN-1:0]  hi_data_q, hi_data_d;
    logic [NB-1:0]    hi_strb_q, hi_strb_d;
    logic [XLEN-1:0]  fault_addr_q, fault_addr_d;
    logic             fault_q, fault_d;

    logic [XLEN-1:0]  ea;
    logic [2*NB-1:0]  ext_strb;
    logic [2*XLEN-1:0] ext_data;
    logic             fault;

    store_lane_align #(
        .XLEN             (XLEN),
        .SPLIT_MISALIGNED (SPLIT_MISALIGNED)
    ) u_align (
        .base     (i_base),
        .offset   (i_offset),
        .data     (i_data),
        .size     (store_size_e'(i_size)),
        .ea       (ea),
        .ext_strb (ext_strb),
        .ext_data (ext_data),
        .fault    (fault)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        hi_data_d    = hi_data_q;
        hi_strb_d    = hi_strb_q;
        fault_addr_d = fault_addr_q;
        fault_d      = fault_q;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (fault) begin
                        state_d      = DONE;
                        fault_d      = 1'b1;
                        fault_addr_d = ea;
                    end else begin
                        state_d   = BEAT0;
                        fault_d   = 1'b0;
                        addr_d    = ea & ALIGN_MASK;
                        wdata_d   = ext_data[XLEN-1:0];
                        wstrb_d   = ext_strb[NB-1:0];
                        hi_data_d = ext_data[2*XLEN-1:XLEN];
                        hi_strb_d = ext_strb[2*NB-1:NB];
                    end
                end
            end
            BEAT0: begin
                if (i_mem_ready) begin
                    if (|hi_strb_q) begin
                        state_d = BEAT1;
                        addr_d  = addr_q + XLEN'(NB);
                        wdata_d = hi_data_q;
                        wstrb_d = hi_strb_q;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BEAT1: begin
                if (i_mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            hi_data_q    <= '0;
            hi_strb_q    <= '0;
            fault_addr_q <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            hi_data_q    <= hi_data_d;
            hi_strb_q    <= hi_strb_d;
            fault_addr_q <= fault_addr_d;
            fault_q      <= fault_d;
        end
    end

    assign o_ready      = (state_q == IDLE);
    assign o_mem_valid  = (state_q == BEAT0) || (state_q == BEAT1);
    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_wstrb  = wstrb_q;
    assign o_done       = (state_q == DONE);
    assign o_fault      = (state_q == DONE) && fault_q;
    assign o_fault_addr = fault_addr_q;

endmodule

// File: tb/tb_store_beat_sequencer.sv
// Bench for store_beat_sequencer: three configurations (32 split, 32 no-split, 64 split)
// share stimulus and are checked every cycle against a byte-level store model.
module tb_store_beat_sequencer;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } beat_t;

    localparam int XL [3] = '{32, 32, 64};
    localparam bit SP [3] = '{1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_size = 2'd0;
    logic [63:0] in_base = '0;
    logic [63:0] in_off = '0;
    logic [63:0] in_data = '0;
    logic [2:0]  mem_rdy = 3'b111;

    logic        r0, v0, dn0, ft0, r1, v1, dn1, ft1, r2, v2, dn2, ft2;
    logic [31:0] ad0, wd0, fa0, ad1, wd1, fa1;
    logic [3:0]  ws0, ws1;
    logic [63:0] ad2, wd2, fa2;
    logic [7:0]  ws2;

    logic [63:0] a_addr [3];
    logic [63:0] a_data [3];
    logic [63:0] a_faddr [3];
    logic [7:0]  a_strb [3];
    logic        a_ready [3];
    logic        a_valid [3];
    logic        a_done [3];
    logic        a_fault [3];

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;

    // Model state per configuration.
    bit          e_ready [3] = '{1'b1, 1'b1, 1'b1};
    bit          e_valid [3] = '{1'b0, 1'b0, 1'b0};
    bit          e_done [3] = '{1'b0, 1'b0, 1'b0};
    bit          e_fault [3] = '{1'b0, 1'b0, 1'b0};
    logic [63:0] e_faddr [3];
    beat_t       pb [3][2];
    int          pi [3] = '{0, 0, 0};
    int          pcnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    store_beat_sequencer #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(r0), .i_size(in_size),
        .i_base(in_base[31:0]), .i_offset(in_off[31:0]), .i_data(in_data[31:0]),
        .o_mem_valid(v0), .i_mem_ready(mem_rdy[0]), .o_mem_addr(ad0), .o_mem_wdata(wd0),
        .o_mem_wstrb(ws0), .o_done(dn0), .o_fault(ft0), .o_fault_addr(fa0)
    );

    store_beat_sequencer #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) u_dut32_nosplit (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(r1), .i_size(in_size),
        .i_base(in_base[31:0]), .i_offset(in_off[31:0]), .i_data(in_data[31:0]),
        .o_mem_valid(v1), .i_mem_ready(mem_rdy[1]), .o_mem_addr(ad1), .o_mem_wdata(wd1),
        .o_mem_wstrb(ws1), .o_done(dn1), .o_fault(ft1), .o_fault_addr(fa1)
    );

    store_beat_sequencer #(.XLEN(64), .SPLIT_MISALIGNED(1'b1)) u_dut64 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(r2), .i_size(in_size),
        .i_base(in_base), .i_offset(in_off), .i_data(in_data),
        .o_mem_valid(v2), .i_mem_ready(mem_rdy[2]), .o_mem_addr(ad2), .o_mem_wdata(wd2),
        .o_mem_wstrb(ws2), .o_done(dn2), .o_fault(ft2), .o_fault_addr(fa2)
    );

    assign a_addr[0] = {32'd0, ad0};
    assign a_addr[1] = {32'd0, ad1};
    assign a_addr[2] = ad2;
    assign a_data[0] = {32'd0, wd0};
    assign a_data[1] = {32'd0, wd1};
    assign a_data[2] = wd2;
    assign a_faddr[0] = {32'd0, fa0};
    assign a_faddr[1] = {32'd0, fa1};
    assign a_faddr[2] = fa2;
    assign a_strb[0] = {4'd0, ws0};
    assign a_strb[1] = {4'd0, ws1};
    assign a_strb[2] = ws2;
    assign a_ready[0] = r0;
    assign a_ready[1] = r1;
    assign a_ready[2] = r2;
    assign a_valid[0] = v0;
    assign a_valid[1] = v1;
    assign a_valid[2] = v2;
    assign a_done[0] = dn0;
    assign a_done[1] = dn1;
    assign a_done[2] = dn2;
    assign a_fault[0] = ft0;
    assign a_fault[1] = ft1;
    assign a_fault[2] = ft2;

    task automatic chk(input string nm, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] xmask(input int xl);
        return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] bytemask(input logic [7:0] s);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    // Place each stored byte at its own address, then group bytes by aligned word.
    task automatic model_accept(input int d);
        logic [63:0] m, ea, a0, a;
        int nbb, nbytes, k, lane;
        beat_t b [2];
        m      = xmask(XL[d]);
        nbb    = XL[d] / 8;
        ea     = (in_base + in_off) & m;
        nbytes = 1 << in_size;
        if ((in_size == 2'd3 && XL[d] == 32) || (!SP[d] && (ea % nbytes) != 0)) begin
            e_ready[d] = 1'b0;
            e_done[d]  = 1'b1;
            e_fault[d] = 1'b1;
            e_faddr[d] = ea;
        end else begin
            a0 = ea - (ea % nbb);
            b[0] = '{addr: a0, data: 64'd0, strb: 8'd0};
            b[1] = '{addr: (a0 + 64'(nbb)) & m, data: 64'd0, strb: 8'd0};
            pcnt[d] = 1;
            for (int i = 0; i < nbytes; i++) begin
                a    = (ea + 64'(i)) & m;
                k    = ((a - (a % nbb)) == a0) ? 0 : 1;
                lane = int'(a % nbb);
                b[k].strb[lane] = 1'b1;
                b[k].data[8*lane +: 8] = in_data[8*i +: 8];
                if (k == 1) pcnt[d] = 2;
            end
            pb[d][0]   = b[0];
            pb[d][1]   = b[1];
            pi[d]      = 0;
            e_ready[d] = 1'b0;
            e_valid[d] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                e_ready[d] = 1'b1;
                e_valid[d] = 1'b0;
                e_done[d]  = 1'b0;
                e_fault[d] = 1'b0;
            end else if (e_done[d]) begin
                e_done[d]  = 1'b0;
                e_fault[d] = 1'b0;
                e_ready[d] = 1'b1;
            end else if (e_valid[d]) begin
                if (mem_rdy[d]) begin
                    pi[d]++;
                    if (pi[d] == pcnt[d]) begin
                        e_valid[d] = 1'b0;
                        e_done[d]  = 1'b1;
                    end
                end
            end else if (e_ready[d] && in_valid) begin
                model_accept(d);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 3; d++) begin
                chk("ready", d, 64'(a_ready[d]), 64'(e_ready[d]));
                chk("mem_valid", d, 64'(a_valid[d]), 64'(e_valid[d]));
                chk("done", d, 64'(a_done[d]), 64'(e_done[d]));
                chk("fault", d, 64'(a_fault[d]), 64'(e_fault[d]));
                if (e_valid[d]) begin
                    chk("addr", d, a_addr[d], pb[d][pi[d]].addr);
                    chk("strb", d, 64'(a_strb[d]), 64'(pb[d][pi[d]].strb));
                    chk("wdata", d, a_data[d] & bytemask(pb[d][pi[d]].strb),
                        pb[d][pi[d]].data & bytemask(pb[d][pi[d]].strb));
                end
                if (e_done[d] && e_fault[d]) chk("fault_addr", d, a_faddr[d], e_faddr[d]);
            end
        end
    end

    task automatic issue(input logic [1:0] sz, input logic [63:0] b, input logic [63:0] o,
                         input logic [63:0] dat);
        @(posedge clk);
        #1;
        in_size  = sz;
        in_base  = b;
        in_off   = o;
        in_data  = dat;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 0, 64'(r0), 64'd1);
        chk("rst_valid", 0, 64'(v0), 64'd0);
        chk("rst_done", 0, 64'(dn0), 64'd0);
        chk("rst_addr", 0, a_addr[0], 64'd0);
        chk("rst_wdata", 0, a_data[0], 64'd0);
        chk("rst_strb_faddr", 0, {a_strb[0], a_faddr[0][55:0]}, 64'd0);
        armed = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Aligned SW: one beat, done two cycles after accept.
        issue(2'd2, 64'h100, 64'h4, 64'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_addr", 0, a_addr[0], 64'h104);
        chk("sw_strb", 0, 64'(a_strb[0]), 64'hF);
        chk("sw_wdata", 0, a_data[0], 64'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_done", 0, 64'(dn0), 64'd1);
        settle();

        // Misaligned SH across a word: split on dut0, fault on dut1.
        issue(2'd1, 64'h100, 64'h3, 64'hABCD);
        @(negedge clk);
        chk("sh_b0_addr", 0, a_addr[0], 64'h100);
        chk("sh_b0_strb", 0, 64'(a_strb[0]), 64'h8);
        chk("sh_b0_byte", 0, 64'(a_data[0][31:24]), 64'hCD);
        chk("sh_nosplit_fault", 1, {62'd0, dn1, ft1}, 64'd3);
        chk("sh_nosplit_faddr", 1, a_faddr[1], 64'h103);
        @(negedge clk);
        chk("sh_b1_addr", 0, a_addr[0], 64'h104);
        chk("sh_b1_strb", 0, 64'(a_strb[0]), 64'h1);
        chk("sh_b1_byte", 0, 64'(a_data[0][7:0]), 64'hAB);
        @(negedge clk);
        chk("sh_done", 0, 64'(dn0), 64'd1);
        settle();

        // SW at the top of the 32-bit space: second beat wraps to zero.
        issue(2'd2, 64'hFFFF_FFF0, 64'hE, 64'h1122_3344);
        @(negedge clk);
        chk("wrap_b0_addr", 0, a_addr[0], 64'hFFFF_FFFC);
        chk("wrap_b0_strb", 0, 64'(a_strb[0]), 64'hC);
        @(negedge clk);
        chk("wrap_b1_addr", 0, a_addr[0], 64'h0);
        chk("wrap_b1_strb", 0, 64'(a_strb[0]), 64'h3);
        settle();

        // SD: illegal at XLEN=32, split across two doublewords at XLEN=64.
        issue(2'd3, 64'h10, 64'hC, 64'h0102_0304_0506_0708);
        @(negedge clk);
        chk("sd32_fault", 0, {62'd0, dn0, ft0}, 64'd3);
        chk("sd32_no_valid", 0, 64'(v0), 64'd0);
        chk("sd32_faddr", 0, a_faddr[0], 64'h1C);
        chk("sd64_b0_strb", 2, 64'(a_strb[2]), 64'hF0);
        chk("sd64_b0_addr", 2, a_addr[2], 64'h18);
        @(negedge clk);
        chk("sd64_b1_strb", 2, 64'(a_strb[2]), 64'h0F);
        chk("sd64_b1_addr", 2, a_addr[2], 64'h20);
        settle();

        // Backpressure: beat held stable, new requests ignored.
        mem_rdy = 3'b000;
        issue(2'd2, 64'h200, 64'h0, 64'h1234_5678);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 0, 64'(v0), 64'd1);
            chk("bp_addr", 0, a_addr[0], 64'h200);
            chk("bp_wdata", 0, a_data[0], 64'h1234_5678);
            chk("bp_ready", 0, 64'(r0), 64'd0);
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            in_data  = {$urandom, $urandom};
        end
        in_valid = 1'b0;
        mem_rdy  = 3'b111;
        settle();

        // Reset while the second beat is pending.
        issue(2'd1, 64'h100, 64'h3, 64'hABCD);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstb1_valid_pre", 0, 64'(v0), 64'd1);
        chk("rstb1_addr_pre", 0, a_addr[0], 64'h104);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstb1_valid", 0, 64'(v0), 64'd0);
        chk("rstb1_ready", 0, 64'(r0), 64'd1);
        chk("rstb1_done", 0, 64'(dn0), 64'd0);
        @(negedge clk);
        chk("rstb1_no_done", 0, 64'(dn0), 64'd0);
        settle();

        // Randomized traffic with independent backpressure and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_size  = 2'($urandom_range(0, 3));
            in_base  = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) in_base = 64'hFFFF_FFFF_FFFF_FFF0;
            in_off   = 64'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) in_off = -in_off;
            in_data  = {$urandom, $urandom};
            mem_rdy  = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        mem_rdy  = 3'b111;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
